// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Command and result handshake bundle between the control logic and the
// ALU operation sequencer.
//   cmd_valid / cmd_ready : command handshake (master -> sequencer)
//   cmd_op, cmd_a, cmd_b  : operation code and operands
//   res_valid / res_ready : result handshake (sequencer -> master)
//   res_data, res_carry   : result word and carry flag
// The master modport is the command issuer; the slave modport is the sequencer.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_carry
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Command-side master for a 32-bit combinational ALU. Runs single-cycle ALU
// ops directly, builds shift-by-N from single-bit ALU shifts and unsigned
// multiply (low WIDTH bits) from shift-and-add, and returns the result over
// a valid/ready handshake.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : command/result handshake (slave side)
//   busy       : high whenever the sequencer is not IDLE
//   alu_a/b    : ALU operands, alu_sel : ALU select
//   alu_out    : ALU result, alu_carry : carry of alu_a + alu_b
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SHR1 = 3'b010;
  localparam logic [2:0] SEL_SHL1 = 3'b011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    SHIFT   = 3'd2,
    MUL_ADD = 3'd3,
    MUL_SHL = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;     // operand A; doubles as shift word W and multiplicand
  logic [WIDTH-1:0] b_r;     // operand B; doubles as multiplier
  logic [WIDTH-1:0] acc_r;   // multiply accumulator
  logic [4:0]       cnt_r;   // remaining single-bit shifts
  logic [WIDTH-1:0] res_data_r;
  logic             res_carry_r;

  // Select used in EXEC: op encodings equal ALU selects except MUL (run as ADD).
  function automatic logic [2:0] exec_sel(input logic [2:0] op);
    case (op)
      OP_MUL:  exec_sel = SEL_ADD;
      default: exec_sel = op;
    endcase
  endfunction

  assign bus.cmd_ready = (state_r == IDLE);
  assign bus.res_valid = (state_r == DONE);
  assign bus.res_data  = res_data_r;
  assign bus.res_carry = res_carry_r;
  assign busy          = (state_r != IDLE);

  // Sequencer FSM: command capture, multi-cycle datapath and result holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= 3'b000;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= 5'd0;
      res_data_r  <= {WIDTH{1'b0}};
      res_carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_r        <= bus.cmd_op;
            a_r         <= bus.cmd_a;
            b_r         <= bus.cmd_b;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= bus.cmd_b[4:0];
            res_carry_r <= 1'b0;
            if ((bus.cmd_op == OP_SHR) || (bus.cmd_op == OP_SHL)) begin
              // A zero-count shift is just a pass-through of A.
              if (bus.cmd_b[4:0] == 5'd0) begin
                res_data_r <= bus.cmd_a;
                state_r    <= DONE;
              end else begin
                state_r <= SHIFT;
              end
            end else if ((bus.cmd_op == OP_MUL) && (MUL_EN == 1'b1)) begin
              if (bus.cmd_b == {WIDTH{1'b0}}) begin
                res_data_r <= {WIDTH{1'b0}};
                state_r    <= DONE;
              end else if (bus.cmd_b[0]) begin
                state_r <= MUL_ADD;
              end else begin
                state_r <= MUL_SHL;
              end
            end else begin
              state_r <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_data_r  <= alu_out;
          res_carry_r <= (op_r == OP_ADD) ? alu_carry : 1'b0;
          state_r     <= DONE;
        end
        SHIFT: begin
          a_r   <= alu_out;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            res_data_r <= alu_out;
            state_r    <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        MUL_ADD: begin
          acc_r   <= alu_out;
          state_r <= MUL_SHL;
        end
        MUL_SHL: begin
          a_r <= alu_out;
          b_r <= b_r >> 1;
          // Next multiplier bit is b_r[1]; finish once no set bits remain above it.
          if (b_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}) begin
            res_data_r <= acc_r;
            state_r    <= DONE;
          end else if (b_r[1]) begin
            state_r <= MUL_ADD;
          end else begin
            state_r <= MUL_SHL;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // ALU drive decoded from the registered state; idle/done present zeros.
  always_comb begin
    alu_a   = {WIDTH{1'b0}};
    alu_b   = {WIDTH{1'b0}};
    alu_sel = 3'b000;
    case (state_r)
      EXEC: begin
        alu_a   = a_r;
        alu_b   = b_r;
        alu_sel = exec_sel(op_r);
      end
      SHIFT: begin
        alu_a   = a_r;
        alu_sel = (op_r == OP_SHL) ? SEL_SHL1 : SEL_SHR1;
      end
      MUL_ADD: begin
        alu_a   = acc_r;
        alu_b   = a_r;
        alu_sel = SEL_ADD;
      end
      MUL_SHL: begin
        alu_a   = a_r;
        alu_sel = SEL_SHL1;
      end
      default: begin
        alu_a   = {WIDTH{1'b0}};
        alu_b   = {WIDTH{1'b0}};
        alu_sel = 3'b000;
      end
    endcase
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side master for the 32-bit combinational ALU. It accepts operation requests over a valid/ready handshake, drives the ALU operand and select inputs, and captures the ALU result and carry.
- Builds multi-cycle operations out of the ALU primitives:
  - shift by N, as N single-bit ALU shifts;
  - unsigned multiply (low 32 bits), as shift-and-add.
- Returns the result over a second valid/ready handshake. Sits between the instruction/control logic and the ALU instance.

Parameters:
- WIDTH, 32: data width. Must match the ALU (32).
- MUL_EN, 1: 1 enables op 100 as MUL; 0 executes op 100 as single-cycle ADD.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 SHR, 011 SHL, 100 MUL, 101 AND, 110 OR, 111 XOR
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B; for shifts only cmd_b[4:0] = shift count N
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  result
- res_carry  out  1  carry flag (ADD only)
- busy  out  1  state != IDLE
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_sel  out  3  to ALU select: 000 add, 001 sub, 010 shr1, 011 shl1, 101 and, 110 or, 111 xor
- alu_out  in  WIDTH  from ALU result
- alu_carry  in  1  from ALU carry (carry of A+B, regardless of select)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state IDLE; res_valid 0; res_data 0; res_carry 0; busy 0; cmd_ready 1 from the first cycle after reset.
- ALU outputs: alu_a, alu_b and alu_sel are combinational from registered state. They are all 0 in IDLE and DONE.
- States: IDLE, EXEC, SHIFT, MUL_ADD, MUL_SHL, DONE.
  - cmd_ready = (state == IDLE).
  - Command accepted when cmd_valid & cmd_ready (cycle T). cmd_op, cmd_a and cmd_b are registered at T.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, and MUL when MUL_EN=0):
  - T+1: EXEC; ALU driven with the registered A, B and the matching select.
  - res_data <= alu_out at end of T+1. res_carry <= alu_carry for ADD, 0 otherwise.
  - DONE at T+2: res_valid=1.
- Shifts (SHR/SHL), count N = cmd_b[4:0]:
  - N=0: res_data <= cmd_a at T, DONE at T+1.
  - N>0: SHIFT state for N cycles. Working register W starts at A; each cycle alu_a=W, alu_sel=010/011, W <= alu_out, count decrements.
  - Leaving SHIFT: res_data = W, res_valid at T+N+1, res_carry 0.
- MUL (MUL_EN=1), unsigned, low WIDTH bits:
  - Internal registers: acc (starts 0), mcand (starts A), mplier (starts B).
  - At T: B==0 -> res_data 0, DONE at T+1. Otherwise next state is MUL_ADD if B[0]=1, else MUL_SHL.
  - MUL_ADD: alu_a=acc, alu_b=mcand, sel 000; acc <= alu_out. Next state MUL_SHL.
  - MUL_SHL: alu_a=mcand, sel 011; mcand <= alu_out; mplier <= mplier>>1.
    - If (mplier>>1)==0: res_data <= acc, go to DONE.
    - Else go to MUL_ADD if mplier[1]=1, else MUL_SHL.
  - Cycles = (popcount(B) + index_of_MSB(B) + 1), then DONE. res_carry 0. Carries out of acc are discarded (wrap mod 2^32).
- DONE:
  - res_valid=1; res_data and res_carry held stable until res_ready.
  - On res_valid & res_ready: IDLE next cycle, res_valid 0.
  - No command is accepted in the same cycle as result handshake (cmd_ready=0 in DONE).
- cmd_valid while busy is ignored; the command is not consumed.
- Reset mid-operation: the operation is abandoned. IDLE next cycle, no res_valid ever issued for it, res_data and res_carry cleared.
- Undefined/unused encodings: none. All 8 cmd_op values are defined.

Test Plan:
- ADD, A=FFFFFFFF, B=00000001, res_ready=1 -> res_valid at T+2, res_data=00000000, res_carry=1, cmd_ready high at T+3.
- SUB 0000000A-00000003; XOR F0F0F0F0^0FF00FF0 -> res_data 00000007 and FF00FF00 resp., res_carry=0, latency 2.
- SHL A=00000001, N=31 -> 31 SHIFT cycles with alu_sel=011, res_data=80000000 at T+32. SHR A=80000000, N=0 -> res_data=80000000 at T+1.
- MUL 7x5 -> alu_sel sequence 000, 011, 011, 000, 011; res_data=00000023 at T+6. MUL FFFFFFFFxFFFFFFFF -> res_data=00000001 at T+65. MUL Ax0 -> 0 at T+1.
- Backpressure: res_ready=0 for 5 cycles after res_valid, cmd_valid held high with new command -> res_data stable, cmd_ready=0, second command accepted only the cycle after the handshake.
- Reset asserted one cycle in the middle of MUL 7x5 -> next cycle IDLE, busy=0, res_valid never asserted; a following ADD 2+3 returns 00000005 normally.
